csr_access_ctrl: RTL and testbench
==================================

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 SHALL have parameter CSR_ADDR, default 12, CSR address width.
REQ-002 SHALL have parameter CSR_OP_WIDTH, default 3, CSR op code width.
REQ-003 SHALL have parameter XLEN, default 32, register/data width.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  1  decoded SYSTEM/CSR instruction present.
REQ-007 SHALL have port req_ready_o  output  1  block can accept a request.
REQ-008 SHALL have port funct3_i  input  3  instruction funct3.
REQ-009 SHALL have port csr_addr_i  input  CSR_ADDR  CSR address from instruction.
REQ-010 SHALL have port rs1_idx_i  input  5  rs1 index, also zimm field.
REQ-011 SHALL have port rs1_val_i  input  XLEN  rs1 register value.
REQ-012 SHALL have port rd_idx_i  input  5  destination register index.
REQ-013 SHALL have port csr_addr_o  output  CSR_ADDR  address to CSR unit.
REQ-014 SHALL have port csr_op_o  output  CSR_OP_WIDTH  op to CSR unit: 0 idle, 1 RW, 2 RS, 3 RC, 4 RWI, 5 RSI, 6 RCI.
REQ-015 SHALL have port csr_val_o  output  XLEN  operand to CSR unit.
REQ-016 SHALL have port csr_rdata_i  input  XLEN  registered read value from CSR unit.
REQ-017 SHALL have port wb_valid_o  output  1  register-file write strobe.
REQ-018 SHALL have port wb_rd_o  output  5  write-back register index.
REQ-019 SHALL have port wb_data_o  output  XLEN  write-back data.
REQ-020 SHALL have port illegal_o  output  1  illegal CSR instruction pulse.

Function
REQ-021 SHALL implement FSM IDLE -> ISSUE -> WAIT -> WB -> IDLE; req_ready_o = 1 only in IDLE.
REQ-022 SHALL accept on req_valid_i & req_ready_o at a rising edge, latching all request inputs; inputs ignored outside acceptance.
REQ-023 SHALL map funct3 001/010/011/101/110/111 to csr_op 1/2/3/4/5/6; funct3 000/100 is non-CSR.
REQ-024 SHALL drive csr_op_o nonzero for exactly one cycle (ISSUE, accept+1); csr_op_o = 0 in every other state.
REQ-025 SHALL drive csr_val_o = rs1_val for ops 1-3, zero-extended rs1_idx (zimm) for ops 4-6, 0 when idle.
REQ-026 SHALL, for RS/RC/RSI/RCI with rs1_idx = 0, issue op 2 with csr_val_o = 0 (pure read, no CSR write).
REQ-027 SHALL capture csr_rdata_i into wb_data_o at end of WAIT (accept+2).
REQ-028 SHALL assert wb_valid_o for exactly one cycle in WB (accept+3) with wb_rd_o = latched rd; suppressed when rd = 0.
REQ-029 SHALL hold csr_addr_o = latched address from ISSUE through WB; total request latency 4 cycles, next accept at accept+4 earliest.
REQ-030 SHALL handle non-CSR funct3 (when not flagged illegal): accept, no issue, no write-back, return IDLE at accept+1.

Reset
REQ-031 SHALL on rst_n = 0 immediately force IDLE, req_ready_o = 1 after release, csr_op_o = 0, csr_val_o = 0, csr_addr_o = 0, wb_valid_o = 0, wb_rd_o = 0, wb_data_o = 0, illegal_o = 0.
REQ-032 SHALL abandon any in-flight request on reset mid-operation; no write-back after release.

Configuration
REQ-033 SHALL support macro CSR_ILLEGAL_TRAP_EN.
REQ-034 SHALL, when defined, pulse illegal_o one cycle at accept+1 for funct3 000/100 or a write attempt (op 1/4, or op 2/3/5/6 with rs1_idx != 0) to read-only address (addr[11:10] = 2'b11); no CSR op, no write-back, return IDLE.
REQ-035 SHALL, when undefined, tie illegal_o to 0 and issue read-only-address writes unchanged.

Verification
REQ-036 CSRRS addr 0xC00, rs1_idx 0, rd 5, csr_rdata_i 0x0000_1234 -> csr_op_o 2 with csr_val_o 0 at accept+1; wb_valid_o, wb_rd_o 5, wb_data_o 0x1234 at accept+3.
REQ-037 CSRRWI addr 0x340, zimm 0x1F, rd 0 -> csr_op_o 4, csr_val_o 0x1F one cycle; wb_valid_o stays 0.
REQ-038 Back-to-back req_valid_i held high with two requests -> second accepted exactly 4 cycles after first; req_ready_o low 3 cycles.
REQ-039 rst_n low at accept+2 of CSRRW -> csr_op_o 0, no wb_valid_o after release, req_ready_o 1.
REQ-040 With CSR_ILLEGAL_TRAP_EN: CSRRW addr 0xC80, rs1_idx 3 -> illegal_o 1 at accept+1, csr_op_o stays 0; without macro same stimulus -> csr_op_o 1, illegal_o 0.

Source files
------------

// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: request, CSR-unit and write-back signals of csr_access_ctrl.
interface csr_access_ctrl_if #(
    parameter int CSR_ADDR     = 12,
    parameter int CSR_OP_WIDTH = 3,
    parameter int XLEN         = 32
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [2:0]              funct3_i;
    logic [CSR_ADDR-1:0]     csr_addr_i;
    logic [4:0]              rs1_idx_i;
    logic [XLEN-1:0]         rs1_val_i;
    logic [4:0]              rd_idx_i;
    logic [CSR_ADDR-1:0]     csr_addr_o;
    logic [CSR_OP_WIDTH-1:0] csr_op_o;
    logic [XLEN-1:0]         csr_val_o;
    logic [XLEN-1:0]         csr_rdata_i;
    logic                    wb_valid_o;
    logic [4:0]              wb_rd_o;
    logic [XLEN-1:0]         wb_data_o;
    logic                    illegal_o;
    modport master (
        output req_valid_i, funct3_i, csr_addr_i, rs1_idx_i, rs1_val_i, rd_idx_i, csr_rdata_i,
        input  req_ready_o, csr_addr_o, csr_op_o, csr_val_o, wb_valid_o, wb_rd_o, wb_data_o, illegal_o
    );
    modport slave (
        input  req_valid_i, funct3_i, csr_addr_i, rs1_idx_i, rs1_val_i, rd_idx_i, csr_rdata_i,
        output req_ready_o, csr_addr_o, csr_op_o, csr_val_o, wb_valid_o, wb_rd_o, wb_data_o, illegal_o
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences one CSR instruction through issue, read wait and write-back.
// Optional CSR_ILLEGAL_TRAP_EN flags non-CSR funct3 and writes to read-only CSRs as illegal.
module csr_access_ctrl #(
    parameter int CSR_ADDR     = 12,
    parameter int CSR_OP_WIDTH = 3,
    parameter int XLEN         = 32
) (
    input logic clk,
    input logic rst_n,
    csr_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
    state_t state;
    logic non_csr, pure_read, read_only, illegal;
    logic [CSR_OP_WIDTH-1:0] op_sel;
    logic [XLEN-1:0] val_sel;
    // set/clear with rs1 = x0 / zimm = 0 degrades to a plain read
    assign non_csr   = bus.funct3_i[1:0] == 2'b00;
    assign pure_read = bus.funct3_i[1] && bus.rs1_idx_i == 5'd0;
    assign read_only = bus.csr_addr_i[CSR_ADDR-1 -: 2] == 2'b11;
    assign op_sel    = pure_read ? CSR_OP_WIDTH'(2)
                     : CSR_OP_WIDTH'({1'b0, bus.funct3_i[1:0]} + (bus.funct3_i[2] ? 3'd3 : 3'd0));
    assign val_sel   = pure_read ? '0 : bus.funct3_i[2] ? XLEN'(bus.rs1_idx_i) : bus.rs1_val_i;
`ifdef CSR_ILLEGAL_TRAP_EN
    assign illegal   = non_csr || (!pure_read && read_only);
`else
    assign illegal   = 1'b0;
`endif
    assign bus.req_ready_o = state == IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.csr_addr_o <= '0;
            bus.csr_op_o   <= '0;
            bus.csr_val_o  <= '0;
            bus.wb_valid_o <= 1'b0;
            bus.wb_rd_o    <= '0;
            bus.wb_data_o  <= '0;
            bus.illegal_o  <= 1'b0;
        end else begin
            bus.csr_op_o   <= '0;
            bus.csr_val_o  <= '0;
            bus.wb_valid_o <= 1'b0;
            bus.illegal_o  <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid_i) begin
                    bus.csr_addr_o <= bus.csr_addr_i;
                    bus.wb_rd_o    <= bus.rd_idx_i;
                    bus.illegal_o  <= illegal;
                    if (!non_csr && !illegal) begin
                        bus.csr_op_o  <= op_sel;
                        bus.csr_val_o <= val_sel;
                        state         <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    bus.wb_data_o  <= bus.csr_rdata_i;
                    bus.wb_valid_o <= bus.wb_rd_o != 5'd0;
                    state          <= WB;
                end
                WB: state <= IDLE;
            endcase
        end
    end
    // read_only is only consumed by the trap build
    logic unused;
    assign unused = read_only;
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed vector table plus back-to-back and mid-flight reset sequences.
module tb_csr_access_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    csr_access_ctrl_if bus ();
    csr_access_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1;
        logic [31:0] rv;
        logic [4:0]  rd;
        logic [31:0] rdat;
        logic [2:0]  op;
        logic [31:0] val;
        logic        ill;
    } vec_t;
    vec_t tv[14];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask
    task automatic idle_inputs();
        bus.req_valid_i = 1'b0;
        bus.funct3_i    = 3'b001;
        bus.csr_addr_i  = 12'hABC;
        bus.rs1_idx_i   = 5'd17;
        bus.rs1_val_i   = 32'hCAFE_F00D;
        bus.rd_idx_i    = 5'd21;
    endtask
    task automatic run_vec(input vec_t v, input int i);
        logic [2:0] eop;
        logic eill, ewb;
        string n;
        n = $sformatf("v%0d", i);
`ifdef CSR_ILLEGAL_TRAP_EN
        eill = v.ill;
        eop  = v.ill ? 3'd0 : v.op;
`else
        eill = 1'b0;
        eop  = v.op;
`endif
        ewb = eop != 3'd0 && v.rd != 5'd0;
        bus.req_valid_i = 1'b1;
        bus.funct3_i    = v.f3;
        bus.csr_addr_i  = v.addr;
        bus.rs1_idx_i   = v.rs1;
        bus.rs1_val_i   = v.rv;
        bus.rd_idx_i    = v.rd;
        chk({n, "_ready"}, 32'(bus.req_ready_o), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        bus.csr_rdata_i = v.rdat;
        chk({n, "_op"}, 32'(bus.csr_op_o), 32'(eop));
        chk({n, "_val"}, bus.csr_val_o, eop != 3'd0 ? v.val : 32'd0);
        chk({n, "_ill"}, 32'(bus.illegal_o), 32'(eill));
        if (eop != 3'd0) chk({n, "_addr"}, 32'(bus.csr_addr_o), 32'(v.addr));
        @(posedge clk); #1;
        chk({n, "_op_end"}, 32'(bus.csr_op_o), 32'd0);
        chk({n, "_ill_end"}, 32'(bus.illegal_o), 32'd0);
        chk({n, "_ready1"}, 32'(bus.req_ready_o), 32'(eop == 3'd0));
        if (eop != 3'd0) chk({n, "_addr_hold"}, 32'(bus.csr_addr_o), 32'(v.addr));
        @(posedge clk); #1;
        chk({n, "_wbv"}, 32'(bus.wb_valid_o), 32'(ewb));
        if (ewb) begin
            chk({n, "_wbrd"}, 32'(bus.wb_rd_o), 32'(v.rd));
            chk({n, "_wbdata"}, bus.wb_data_o, v.rdat);
        end
        @(posedge clk); #1;
        chk({n, "_wbv_end"}, 32'(bus.wb_valid_o), 32'd0);
        chk({n, "_ready3"}, 32'(bus.req_ready_o), 32'd1);
    endtask
    initial begin
        tv[0]  = '{3'b010, 12'hC00, 5'd0,  32'h0000_0000, 5'd5,  32'h0000_1234, 3'd2, 32'h0,         1'b0};
        tv[1]  = '{3'b101, 12'h340, 5'h1F, 32'h1111_1111, 5'd0,  32'h0000_AAAA, 3'd4, 32'h1F,        1'b0};
        tv[2]  = '{3'b001, 12'h300, 5'd3,  32'hDEAD_BEEF, 5'd7,  32'h0000_0055, 3'd1, 32'hDEAD_BEEF, 1'b0};
        tv[3]  = '{3'b011, 12'h341, 5'd2,  32'h0000_0F0F, 5'd1,  32'h8000_0000, 3'd3, 32'h0000_0F0F, 1'b0};
        tv[4]  = '{3'b110, 12'h344, 5'h11, 32'h2222_2222, 5'd31, 32'hFFFF_FFFF, 3'd5, 32'h11,        1'b0};
        tv[5]  = '{3'b111, 12'h305, 5'd0,  32'h3333_3333, 5'd9,  32'h0000_0077, 3'd2, 32'h0,         1'b0};
        tv[6]  = '{3'b111, 12'h305, 5'h1E, 32'h4444_4444, 5'd2,  32'h0000_0099, 3'd6, 32'h1E,        1'b0};
        tv[7]  = '{3'b110, 12'hB00, 5'd0,  32'h5555_5555, 5'd3,  32'h0000_0042, 3'd2, 32'h0,         1'b0};
        tv[8]  = '{3'b011, 12'hC01, 5'd0,  32'h6666_6666, 5'd4,  32'h0000_0010, 3'd2, 32'h0,         1'b0};
        tv[9]  = '{3'b001, 12'hC80, 5'd3,  32'h1234_5678, 5'd6,  32'h0000_0005, 3'd1, 32'h1234_5678, 1'b1};
        tv[10] = '{3'b101, 12'hC00, 5'd0,  32'h7777_7777, 5'd8,  32'h0000_0006, 3'd4, 32'h0,         1'b1};
        tv[11] = '{3'b010, 12'hF14, 5'd4,  32'h0000_00F0, 5'd10, 32'h0000_0007, 3'd2, 32'h0000_00F0, 1'b1};
        tv[12] = '{3'b000, 12'h300, 5'd1,  32'h8888_8888, 5'd11, 32'h0000_0008, 3'd0, 32'h0,         1'b1};
        tv[13] = '{3'b100, 12'h341, 5'd2,  32'h9999_9999, 5'd12, 32'h0000_0009, 3'd0, 32'h0,         1'b1};
        idle_inputs();
        bus.csr_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op", 32'(bus.csr_op_o), 32'd0);
        chk("rst_val", bus.csr_val_o, 32'd0);
        chk("rst_addr", 32'(bus.csr_addr_o), 32'd0);
        chk("rst_wbv", 32'(bus.wb_valid_o), 32'd0);
        chk("rst_wbrd", 32'(bus.wb_rd_o), 32'd0);
        chk("rst_wbdata", bus.wb_data_o, 32'd0);
        chk("rst_ill", 32'(bus.illegal_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
        for (int i = 0; i < 14; i++) run_vec(tv[i], i);
        // back-to-back: valid held high across two requests
        bus.req_valid_i = 1'b1;
        bus.funct3_i    = 3'b001;
        bus.csr_addr_i  = 12'h300;
        bus.rs1_idx_i   = 5'd1;
        bus.rs1_val_i   = 32'h0000_A5A5;
        bus.rd_idx_i    = 5'd11;
        @(posedge clk); #1;
        chk("b2b_op1", 32'(bus.csr_op_o), 32'd1);
        chk("b2b_val1", bus.csr_val_o, 32'h0000_A5A5);
        bus.funct3_i    = 3'b110;
        bus.csr_addr_i  = 12'h301;
        bus.rs1_idx_i   = 5'd5;
        bus.rd_idx_i    = 5'd12;
        bus.csr_rdata_i = 32'h0000_0111;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b_busy%0d", k), 32'(bus.req_ready_o), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("b2b_noop%0d", k), 32'(bus.csr_op_o), 32'd0);
        end
        chk("b2b_wbrd1", 32'(bus.wb_rd_o), 32'd11);
        chk("b2b_ready", 32'(bus.req_ready_o), 32'd1);
        bus.csr_rdata_i = 32'h0000_0222;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        chk("b2b_op2", 32'(bus.csr_op_o), 32'd5);
        chk("b2b_val2", bus.csr_val_o, 32'd5);
        chk("b2b_addr2", 32'(bus.csr_addr_o), 32'h301);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_wbv2", 32'(bus.wb_valid_o), 32'd1);
        chk("b2b_wbrd2", 32'(bus.wb_rd_o), 32'd12);
        chk("b2b_wbdata2", bus.wb_data_o, 32'h0000_0222);
        @(posedge clk); #1;
        idle_inputs();
        // reset while the CSRRW is waiting for read data
        bus.req_valid_i = 1'b1;
        bus.funct3_i    = 3'b001;
        bus.csr_addr_i  = 12'h305;
        bus.rs1_idx_i   = 5'd6;
        bus.rs1_val_i   = 32'h0BAD_0BAD;
        bus.rd_idx_i    = 5'd5;
        bus.csr_rdata_i = 32'h0000_0333;
        @(posedge clk); #1;
        idle_inputs();
        chk("rmid_op", 32'(bus.csr_op_o), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rmid_op0", 32'(bus.csr_op_o), 32'd0);
        chk("rmid_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rmid_addr", 32'(bus.csr_addr_o), 32'd0);
        chk("rmid_wbrd", 32'(bus.wb_rd_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rmid_nowb%0d", k), 32'(bus.wb_valid_o), 32'd0);
        end
        chk("rmid_ready_end", 32'(bus.req_ready_o), 32'd1);
        chk("rmid_wbdata", bus.wb_data_o, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
